// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_t;

    // Stream framing: 16-bit little-endian word count, payload, 8-bit sum.
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned CSUM_BYTES = 1;

    // Full-byte write mask (active-low bit enables).
    localparam logic [7:0] WEN_ALL_BYTES = 8'h00;

    // States in which the loader, not the core, drives the SRAM banks.
    function automatic logic loader_owns(loader_state_t s);
        return (s == StHdr0) || (s == StHdr1) || (s == StData) || (s == StCsum);
    endfunction

endpackage

// File: rtl/imem_port_mux.sv
// Per-lane SRAM port ownership mux: loader drive while loading, core passthrough otherwise.
module imem_port_mux #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              owned,
    input  logic              ld_cen,
    input  logic              ld_gwen,
    input  logic [7:0]        ld_wen,
    input  logic [ADDR_W-1:0] ld_a,
    input  logic [7:0]        ld_d,
    input  logic              cpu_cen,
    input  logic              cpu_gwen,
    input  logic [7:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_d,
    output logic              mem_cen,
    output logic              mem_gwen,
    output logic [7:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_d
);

    // Select the bank driver; purely combinational so the core sees no added latency.
    always_comb begin
        mem_cen  = cpu_cen;
        mem_gwen = cpu_gwen;
        mem_wen  = cpu_wen;
        mem_a    = cpu_a;
        mem_d    = cpu_d;
        if (owned) begin
            mem_cen  = ld_cen;
            mem_gwen = ld_gwen;
            mem_wen  = ld_wen;
            mem_a    = ld_a;
            mem_d    = ld_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the banked instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter bit          AUTO_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    input  logic              CEN_cpu  [0:LANES-1],
    input  logic              GWEN_cpu [0:LANES-1],
    input  logic [7:0]        WEN_cpu  [0:LANES-1],
    input  logic [ADDR_W-1:0] A_cpu    [0:LANES-1],
    input  logic [7:0]        D_cpu    [0:LANES-1],
    output logic              CEN_mem  [0:LANES-1],
    output logic              GWEN_mem [0:LANES-1],
    output logic [7:0]        WEN_mem  [0:LANES-1],
    output logic [ADDR_W-1:0] A_mem    [0:LANES-1],
    output logic [7:0]        D_mem    [0:LANES-1]
);

    localparam int unsigned   LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
    localparam int unsigned   DEPTH    = 1 << ADDR_W;
    localparam loader_state_t RESET_ST = AUTO_LOAD ? StHdr0 : StIdle;

    loader_state_t     state_q;
    logic [LANE_W-1:0] lane_q;
    logic [ADDR_W:0]   addr_q;
    logic [7:0]        sum_q;
    logic [15:0]       count_q;
    logic [7:0]        hdr_lo_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic        owned;
    logic        accept;
    logic [15:0] hdr_n;
    logic        last_data;

    assign owned     = loader_owns(state_q);
    assign in_ready  = owned;
    assign accept    = in_valid && in_ready;
    assign hdr_n     = {in_data, hdr_lo_q};
    // Address counter is one bit wider so a full-depth image is representable.
    assign last_data = (lane_q == LANE_MAX) && ((32'(addr_q) + 32'd1) == 32'(count_q));

    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

    // Load FSM, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RESET_ST;
            lane_q     <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            hdr_lo_q   <= '0;
            cpu_hold_q <= AUTO_LOAD;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Status follows the state one edge later.
            cpu_hold_q <= (state_q != StIdle) && (state_q != StDone);
            done_q     <= (state_q == StDone);
            err_q      <= (state_q == StErr);
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q <= StHdr0;
                        lane_q  <= '0;
                        addr_q  <= '0;
                        sum_q   <= '0;
                        count_q <= '0;
                    end
                end
                StHdr0: begin
                    if (accept) begin
                        hdr_lo_q <= in_data;
                        state_q  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (accept) begin
                        count_q <= hdr_n;
                        if (32'(hdr_n) > DEPTH) begin
                            state_q <= StErr;
                        end else if (hdr_n == 16'd0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        sum_q <= sum_q + in_data;
                        if (lane_q == LANE_MAX) begin
                            lane_q <= '0;
                            addr_q <= addr_q + {{ADDR_W{1'b0}}, 1'b1};
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                        end
                        if (last_data) begin
                            state_q <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        state_q <= (in_data == sum_q) ? StDone : StErr;
                    end
                end
                default: state_q <= RESET_ST;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic ld_sel;
        // Only the lane addressed by the accepted data byte is enabled.
        assign ld_sel = (state_q == StData) && accept && (lane_q == LANE_W'(l));

        imem_port_mux #(
            .ADDR_W(ADDR_W)
        ) u_mux (
            .owned    (owned),
            .ld_cen   (!ld_sel),
            .ld_gwen  (!ld_sel),
            .ld_wen   (WEN_ALL_BYTES),
            .ld_a     (addr_q[ADDR_W-1:0]),
            .ld_d     (in_data),
            .cpu_cen  (CEN_cpu[l]),
            .cpu_gwen (GWEN_cpu[l]),
            .cpu_wen  (WEN_cpu[l]),
            .cpu_a    (A_cpu[l]),
            .cpu_d    (D_cpu[l]),
            .mem_cen  (CEN_mem[l]),
            .mem_gwen (GWEN_mem[l]),
            .mem_wen  (WEN_mem[l]),
            .mem_a    (A_mem[l]),
            .mem_d    (D_mem[l])
        );
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected bank writes queued at drive time, popped on write.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, cpu_hold, done, err;
    logic [7:0] in_data;
    logic              CEN_cpu  [0:LANES-1];
    logic              GWEN_cpu [0:LANES-1];
    logic [7:0]        WEN_cpu  [0:LANES-1];
    logic [ADDR_W-1:0] A_cpu    [0:LANES-1];
    logic [7:0]        D_cpu    [0:LANES-1];
    logic              CEN_mem  [0:LANES-1];
    logic              GWEN_mem [0:LANES-1];
    logic [7:0]        WEN_mem  [0:LANES-1];
    logic [ADDR_W-1:0] A_mem    [0:LANES-1];
    logic [7:0]        D_mem    [0:LANES-1];

    always #5 clk = ~clk;

    imem_loader #(
        .LANES     (LANES),
        .ADDR_W    (ADDR_W),
        .AUTO_LOAD (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .CEN_cpu  (CEN_cpu),
        .GWEN_cpu (GWEN_cpu),
        .WEN_cpu  (WEN_cpu),
        .A_cpu    (A_cpu),
        .D_cpu    (D_cpu),
        .CEN_mem  (CEN_mem),
        .GWEN_mem (GWEN_mem),
        .WEN_mem  (WEN_mem),
        .A_mem    (A_mem),
        .D_mem    (D_mem)
    );

    int vectors     = 0;
    int miscompares = 0;
    int accepted    = 0;
    bit mon_en      = 1'b1;

    logic [7:0]  bank [LANES][DEPTH];
    logic [7:0]  img  [LANES*DEPTH];
    logic [26:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [26:0] wr_word(input int lane, input logic [ADDR_W-1:0] a,
                                            input logic [7:0] wen, input logic [7:0] d);
        logic [1:0] ln;
        ln = lane[1:0];
        return {ln, a, wen, d};
    endfunction

    function automatic logic [26:0] port_word(input logic cen, input logic gwen,
                                              input logic [7:0] wen, input logic [ADDR_W-1:0] a,
                                              input logic [7:0] d);
        return {cen, gwen, wen, a, d};
    endfunction

    // Bank model and write scoreboard, sampled mid-cycle ahead of the accepting edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (!CEN_mem[l] && !GWEN_mem[l]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (!WEN_mem[l][b]) bank[l][A_mem[l]][b] = D_mem[l][b];
                    end
                    if (exp_q.size() == 0) begin
                        check("wr_spurious", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("wr", 32'(wr_word(l, A_mem[l], WEN_mem[l], D_mem[l])),
                              32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_idle();
        for (int l = 0; l < LANES; l++) begin
            CEN_cpu[l] = 1'b1; GWEN_cpu[l] = 1'b1; WEN_cpu[l] = 8'hFF;
            A_cpu[l] = '0; D_cpu[l] = 8'h00;
        end
    endtask

    // Core tries to write while the loader owns the banks; must not reach the SRAM.
    task automatic cpu_hostile();
        for (int l = 0; l < LANES; l++) begin
            CEN_cpu[l] = 1'b0; GWEN_cpu[l] = 1'b0; WEN_cpu[l] = 8'h00;
            A_cpu[l] = ADDR_W'(l * 7); D_cpu[l] = 8'hEE;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data, input int idx);
        int waitc = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 50) begin
            idle(1);
            waitc++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (is_data) exp_q.push_back(wr_word(idx % LANES, ADDR_W'(idx / LANES), 8'h00, b));
        idle(1);
        accepted++;
        in_valid = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] csum_adj, input bit gaps);
        logic [7:0]  s;
        logic [15:0] nn;
        s  = 8'h00;
        nn = 16'(n);
        send_byte(nn[7:0], 1'b0, 0);
        send_byte(nn[15:8], 1'b0, 0);
        for (int k = 0; k < n * LANES; k++) begin
            if (gaps && $urandom_range(2) == 0) idle($urandom_range(3, 1));
            send_byte(img[k], 1'b1, k);
            s = s + img[k];
        end
        send_byte(s + csum_adj, 1'b0, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  prog [8];
        logic [3:0]  cens;
        prog = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h6F};
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_idle();
        for (int l = 0; l < LANES; l++)
            for (int a = 0; a < DEPTH; a++) bank[l][a] = 8'h00;
        idle(2);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        idle(1);

        // Basic two-word load with correct checksum 0x25.
        for (int k = 0; k < 8; k++) img[k] = prog[k];
        cpu_hostile();
        load(2, 8'h00, 1'b0);
        cpu_idle();
        idle(2);
        check("t1_l0a0", 32'(bank[0][0]), 32'h13);
        check("t1_l3a0", 32'(bank[3][0]), 32'h93);
        check("t1_l1a1", 32'(bank[1][1]), 32'h10);
        check("t1_l3a1", 32'(bank[3][1]), 32'h6F);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd0);

        // Passthrough after DONE.
        mon_en = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            CEN_cpu[l] = l[0]; GWEN_cpu[l] = ~l[0]; WEN_cpu[l] = 8'h5A ^ 8'(l);
            A_cpu[l] = ADDR_W'(l * 37 + 3); D_cpu[l] = 8'hC0 + 8'(l);
        end
        #1;
        for (int l = 0; l < LANES; l++)
            check("t1_pass", 32'(port_word(CEN_mem[l], GWEN_mem[l], WEN_mem[l], A_mem[l], D_mem[l])),
                  32'(port_word(l[0], ~l[0], 8'h5A ^ 8'(l), ADDR_W'(l * 37 + 3), 8'hC0 + 8'(l))));
        cpu_idle();
        #1;
        mon_en = 1'b1;

        // Bad checksum 0x24 then a good reload.
        pulse_start();
        cpu_hostile();
        #1;
        for (int l = 0; l < LANES; l++) cens[l] = CEN_mem[l];
        check("t2_isolate", 32'(cens), 32'hF);
        load(2, 8'hFF, 1'b0);
        cpu_idle();
        idle(2);
        check("t2_err", 32'(err), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        pulse_start();
        load(2, 8'h00, 1'b0);
        idle(2);
        check("t2_redone", 32'(done), 32'd1);
        check("t2_reerr", 32'(err), 32'd0);

        // Empty image: header plus checksum only, no writes.
        pulse_start();
        accepted = 0;
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        check("t3_csum_ready", 32'(in_ready), 32'd1);
        send_byte(8'h00, 1'b0, 0);
        check("t3_after_ready", 32'(in_ready), 32'd0);
        check("t3_accepted", 32'(accepted), 32'(HDR_BYTES + CSUM_BYTES));
        idle(2);
        check("t3_done", 32'(done), 32'd1);

        // Oversize header N=513.
        pulse_start();
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        check("t4_ready", 32'(in_ready), 32'd0);
        idle(2);
        check("t4_err", 32'(err), 32'd1);
        check("t4_done", 32'(done), 32'd0);

        // Full-depth image with random valid gaps.
        pulse_start();
        for (int k = 0; k < LANES * DEPTH; k++) img[k] = 8'($urandom);
        load(DEPTH, 8'h00, 1'b1);
        idle(2);
        check("t5_done", 32'(done), 32'd1);
        for (int k = 0; k < LANES * DEPTH; k++)
            check("t5_image", 32'(bank[k % LANES][k / LANES]), 32'(img[k]));
        check("t5_addr", 32'(dut.addr_q), 32'(DEPTH));

        // Reset mid-load, start ignored in DATA, then auto reload.
        pulse_start();
        for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
        send_byte(8'h04, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        for (int k = 0; k < 5; k++) send_byte(img[k], 1'b1, k);
        pulse_start();
        check("t6_ready_data", 32'(in_ready), 32'd1);
        send_byte(img[5], 1'b1, 5);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        check("t6_rst_hold", 32'(cpu_hold), 32'd1);
        check("t6_rst_done", 32'(done), 32'd0);
        load(4, 8'h00, 1'b0);
        idle(2);
        check("t6_done", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++)
            check("t6_image", 32'(bank[k % LANES][k / LANES]), 32'(img[k]));
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
